// File: rtl/instr_loader.sv
// Boot-time program loader: parses a framed byte stream into little-endian 32-bit
// words, writes them to instruction memory, and holds the core until the checksum passes.
module instr_loader #(
   parameter int ADDR_W  = 10,
   parameter int TIMEOUT = 100000
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              rx_valid,
   input  logic [7:0]        rx_data,
   output logic              im_we,
   output logic [ADDR_W-1:0] im_waddr,
   output logic [31:0]       im_wdata,
   output logic              cpu_hold,
   output logic              load_done,
   output logic              load_err,
   output logic              busy,
   output logic [2:0]        state_dbg
);

   // rx_valid is a one-cycle strobe with no ready: every strobed byte is consumed
   // in the cycle it appears; im_we is a one-cycle pulse with no acknowledge.
   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LEN_LO = 3'd1,
      S_LEN_HI = 3'd2,
      S_DATA   = 3'd3,
      S_CSUM   = 3'd4,
      S_RUN    = 3'd5
   } state_t;

   localparam logic [7:0]  SYNC      = 8'hA5;
   localparam logic [16:0] MAX_WORDS = 17'd1 << ADDR_W;
   localparam int          TW        = $clog2(TIMEOUT + 1);
   localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

   state_t        state;
   state_t        state_nxt;
   logic [7:0]    len_lo;
   logic [15:0]   len;
   logic [16:0]   word_cnt;
   logic [1:0]    byte_cnt;
   logic [23:0]   word_buf;
   logic [7:0]    xor_acc;
   logic [TW-1:0] to_cnt;

   logic [15:0]   len_in;
   logic          len_too_big;
   logic          last_byte;
   logic          last_word;
   logic          csum_ok;
   logic          timeout_hit;
   logic          start_frame;

   assign len_in      = {rx_data, len_lo};
   assign len_too_big = {1'b0, len_in} > MAX_WORDS;
   assign last_byte   = (byte_cnt == 2'd3);
   assign last_word   = (word_cnt == ({1'b0, len} - 17'd1));
   assign csum_ok     = (rx_data == xor_acc);
   // A byte arriving on the expiring cycle wins over the timeout.
   assign timeout_hit = busy && !rx_valid && (to_cnt == TO_LAST);
   assign start_frame = rx_valid && (rx_data == SYNC) &&
                        ((state == S_IDLE) || (state == S_RUN));

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) state <= S_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (timeout_hit) begin
         state_nxt = S_IDLE;
      end else if (rx_valid) begin
         case (state)
            S_IDLE:   if (rx_data == SYNC) state_nxt = S_LEN_LO;
            S_LEN_LO: state_nxt = S_LEN_HI;
            S_LEN_HI: begin
               if (len_too_big)         state_nxt = S_IDLE;
               else if (len_in == 16'd0) state_nxt = S_CSUM;
               else                     state_nxt = S_DATA;
            end
            S_DATA:   if (last_byte && last_word) state_nxt = S_CSUM;
            S_CSUM:   state_nxt = csum_ok ? S_RUN : S_IDLE;
            S_RUN:    if (rx_data == SYNC) state_nxt = S_LEN_LO;
            default:  state_nxt = S_IDLE;
         endcase
      end
   end

   always_comb begin
      cpu_hold  = 1'b1;
      load_done = 1'b0;
      busy      = 1'b0;
      case (state)
         S_LEN_LO, S_LEN_HI, S_DATA, S_CSUM: busy = 1'b1;
         S_RUN: begin
            cpu_hold  = 1'b0;
            load_done = 1'b1;
         end
         default: ;
      endcase
   end

   assign state_dbg = state;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         im_we    <= 1'b0;
         im_waddr <= '0;
         im_wdata <= '0;
         load_err <= 1'b0;
         len_lo   <= '0;
         len      <= '0;
         word_cnt <= '0;
         byte_cnt <= '0;
         word_buf <= '0;
         xor_acc  <= '0;
         to_cnt   <= '0;
      end else begin
         im_we <= 1'b0;

         if (!busy || rx_valid || timeout_hit) to_cnt <= '0;
         else                                  to_cnt <= to_cnt + 1'b1;

         if (timeout_hit) load_err <= 1'b1;

         if (start_frame) begin
            byte_cnt <= '0;
            word_cnt <= '0;
            xor_acc  <= '0;
            load_err <= 1'b0;
         end

         if (rx_valid) begin
            case (state)
               S_LEN_LO: len_lo <= rx_data;
               S_LEN_HI: begin
                  len <= len_in;
                  if (len_too_big) load_err <= 1'b1;
               end
               S_DATA: begin
                  xor_acc  <= xor_acc ^ rx_data;
                  byte_cnt <= byte_cnt + 2'd1;
                  case (byte_cnt)
                     2'd0: word_buf[7:0]   <= rx_data;
                     2'd1: word_buf[15:8]  <= rx_data;
                     2'd2: word_buf[23:16] <= rx_data;
                     default: begin
                        // Fourth byte completes the word; it goes straight to the write port.
                        im_we    <= 1'b1;
                        im_waddr <= word_cnt[ADDR_W-1:0];
                        im_wdata <= {rx_data, word_buf};
                        word_cnt <= word_cnt + 17'd1;
                     end
                  endcase
               end
               S_CSUM: if (!csum_ok) load_err <= 1'b1;
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_instr_loader.sv
// Randomised bench for instr_loader: frames are built from word lists, expected writes
// and outcomes come from the word lists, and a monitor scores every im_we pulse.
module tb_instr_loader;
   localparam int ADDR_W  = 10;
   localparam int TIMEOUT = 16;

   logic              CLK = 1'b0;
   logic              RST;
   logic              rx_valid;
   logic [7:0]        rx_data;
   logic              im_we;
   logic [ADDR_W-1:0] im_waddr;
   logic [31:0]       im_wdata;
   logic              cpu_hold;
   logic              load_done;
   logic              load_err;
   logic              busy;
   logic [2:0]        state_dbg;

   always #5 CLK = ~CLK;

   instr_loader #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
      .CLK(CLK), .RST(RST), .rx_valid(rx_valid), .rx_data(rx_data),
      .im_we(im_we), .im_waddr(im_waddr), .im_wdata(im_wdata),
      .cpu_hold(cpu_hold), .load_done(load_done), .load_err(load_err),
      .busy(busy), .state_dbg(state_dbg)
   );

   int n_vec = 0;
   int n_err = 0;
   logic [ADDR_W+31:0] exp_q[$];
   logic [31:0]        frame_words[$];
   logic [ADDR_W+31:0] mon_exp;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Scoreboard: every write pulse must match the next expected (address, word).
   always @(negedge CLK) begin
      if (im_we === 1'b1) begin
         check("write_expected", 64'(exp_q.size() != 0), 64'd1);
         if (exp_q.size() != 0) begin
            mon_exp = exp_q.pop_front();
            check("im_write", 64'({im_waddr, im_wdata}), 64'(mon_exp));
         end
      end
   end

   task automatic send_byte(input logic [7:0] b);
      rx_valid = 1'b1;
      rx_data  = b;
      @(negedge CLK);
      rx_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge CLK);
   endtask

   function automatic logic [7:0] model_csum();
      logic [31:0] x = '0;
      foreach (frame_words[i]) x ^= frame_words[i];
      return x[7:0] ^ x[15:8] ^ x[23:16] ^ x[31:24];
   endfunction

   task automatic maybe_gap(input bit gaps);
      if (gaps && ($urandom_range(0, 3) == 0)) idle($urandom_range(1, 3));
   endtask

   task automatic check_ok(input string tag);
      check({tag, "_hold"}, 64'(cpu_hold), 64'd0);
      check({tag, "_done"}, 64'(load_done), 64'd1);
      check({tag, "_err"},  64'(load_err), 64'd0);
      check({tag, "_busy"}, 64'(busy), 64'd0);
   endtask

   task automatic check_err(input string tag);
      check({tag, "_hold"}, 64'(cpu_hold), 64'd1);
      check({tag, "_done"}, 64'(load_done), 64'd0);
      check({tag, "_err"},  64'(load_err), 64'd1);
      check({tag, "_busy"}, 64'(busy), 64'd0);
   endtask

   // Sends sync, length, frame_words and a checksum XORed with csum_flip.
   task automatic send_frame(input string tag, input logic [7:0] csum_flip, input bit gaps);
      int          n  = frame_words.size();
      logic [15:0] nl = 16'(n);
      logic [7:0]  cs = model_csum() ^ csum_flip;
      logic [31:0] w;
      foreach (frame_words[i]) exp_q.push_back({ADDR_W'(i), frame_words[i]});
      send_byte(8'hA5);
      check({tag, "_start_hold"}, 64'(cpu_hold), 64'd1);
      check({tag, "_start_busy"}, 64'(busy), 64'd1);
      check({tag, "_start_done"}, 64'(load_done), 64'd0);
      check({tag, "_start_err"},  64'(load_err), 64'd0);
      maybe_gap(gaps);
      send_byte(nl[7:0]);
      maybe_gap(gaps);
      send_byte(nl[15:8]);
      for (int i = 0; i < n; i++) begin
         w = frame_words[i];
         for (int k = 0; k < 4; k++) begin
            maybe_gap(gaps);
            send_byte(w[8*k +: 8]);
         end
      end
      maybe_gap(gaps);
      send_byte(cs);
      check({tag, "_writes_left"}, 64'(exp_q.size()), 64'd0);
      if (csum_flip == 8'h00) check_ok(tag);
      else                    check_err(tag);
   endtask

   task automatic random_words(input int n);
      frame_words.delete();
      for (int i = 0; i < n; i++) frame_words.push_back($urandom());
   endtask

   task automatic send_junk(input int n);
      logic [7:0] b;
      for (int i = 0; i < n; i++) begin
         b = 8'($urandom_range(0, 255));
         if (b == 8'hA5) b = 8'h00;
         send_byte(b);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: bench did not reach its summary");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic        was_hold;
      logic [31:0] w;
      RST      = 1'b1;
      rx_valid = 1'b0;
      rx_data  = 8'h00;
      idle(3);
      check("rst_we",    64'(im_we), 64'd0);
      check("rst_waddr", 64'(im_waddr), 64'd0);
      check("rst_wdata", 64'(im_wdata), 64'd0);
      check("rst_hold",  64'(cpu_hold), 64'd1);
      check("rst_done",  64'(load_done), 64'd0);
      check("rst_err",   64'(load_err), 64'd0);
      check("rst_busy",  64'(busy), 64'd0);
      check("rst_state", 64'(state_dbg), 64'd0);
      RST = 1'b0;
      idle(2);

      // Two-word directed frame, back-to-back bytes.
      frame_words.delete();
      frame_words.push_back(32'h12345678);
      frame_words.push_back(32'hDEADBEEF);
      send_frame("two_word", 8'h00, 1'b0);

      // Same frame with checksum forced to 0x00.
      send_frame("bad_csum", model_csum(), 1'b0);
      idle(2);
      check("bad_csum_stays_held", 64'(cpu_hold), 64'd1);
      send_frame("recover", 8'h00, 1'b1);

      // Non-sync byte in RUN changes nothing.
      send_byte(8'h00);
      check_ok("run_ignore");

      // Reload from RUN.
      frame_words.delete();
      frame_words.push_back(32'h11223344);
      send_frame("reload", 8'h00, 1'b0);

      // Empty frame goes straight to the checksum.
      frame_words.delete();
      send_frame("empty", 8'h00, 1'b0);

      // One word beyond capacity is rejected right after LEN_HI.
      send_byte(8'hA5);
      send_byte(8'h01);
      send_byte(8'h04);
      check_err("oversize");
      send_junk(8);
      check("oversize_idle_err", 64'(load_err), 64'd1);

      // Exactly full capacity is accepted.
      random_words(1 << ADDR_W);
      send_frame("full", 8'h00, 1'b0);

      // Timeout after three data bytes.
      send_byte(8'hA5);
      send_byte(8'h02);
      send_byte(8'h00);
      send_byte(8'h01);
      send_byte(8'h02);
      send_byte(8'h03);
      idle(TIMEOUT - 1);
      check("to_early_err",  64'(load_err), 64'd0);
      check("to_early_busy", 64'(busy), 64'd1);
      idle(1);
      check_err("timeout");
      random_words(3);
      send_frame("after_to", 8'h00, 1'b1);

      // Randomised frames with junk in between.
      for (int t = 0; t < 12; t++) begin
         send_junk($urandom_range(0, 3));
         was_hold = cpu_hold;
         if ($urandom_range(0, 3) != 0) check("junk_keeps_hold", 64'(cpu_hold), 64'(was_hold));
         random_words($urandom_range(0, 6));
         send_frame("rand", ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00,
                    1'b1);
      end

      // Reset in the middle of DATA.
      w = $urandom();
      send_byte(8'hA5);
      send_byte(8'h04);
      send_byte(8'h00);
      exp_q.push_back({ADDR_W'(0), w});
      for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8]);
      send_byte(8'h5A);
      RST = 1'b1;
      #1;
      check("mid_rst_we",    64'(im_we), 64'd0);
      check("mid_rst_waddr", 64'(im_waddr), 64'd0);
      check("mid_rst_wdata", 64'(im_wdata), 64'd0);
      check("mid_rst_hold",  64'(cpu_hold), 64'd1);
      check("mid_rst_done",  64'(load_done), 64'd0);
      check("mid_rst_err",   64'(load_err), 64'd0);
      check("mid_rst_busy",  64'(busy), 64'd0);
      check("mid_rst_writes_left", 64'(exp_q.size()), 64'd0);
      @(negedge CLK);
      RST = 1'b0;
      idle(1);
      random_words(2);
      send_frame("after_rst", 8'h00, 1'b0);

      idle(4);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
